// File: rtl/dmem_pkg.sv
// +-----------------------------------------------------------------------+
// | dmem_pkg : shared constants and types for the data-memory arbiter     |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package dmem_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 16;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

  typedef logic port_id_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// +-----------------------------------------------------------------------+
// | rr_pick2 : combinational two-way round-robin picker                   |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module rr_pick2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   rr,
  output logic [1:0] win,
  output logic       valid
);

  // rr only breaks ties; a lone requester always wins
  assign win[0] = req[0] & (~req[1] | (rr == 1'b0));
  assign win[1] = req[1] & (~req[0] | (rr == 1'b1));
  assign valid  = |req;

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// +-----------------------------------------------------------------------+
// | dmem_arbiter : zero-fills the data memory, then round-robin shares    |
// | its single port between the load/store unit and the debug loader.    |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_W = dmem_pkg::ADDR_W,
  parameter int DATA_W = dmem_pkg::DATA_W,
  parameter int DEPTH  = dmem_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  import dmem_pkg::*;

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

  arb_state_t        r_state;
  logic [ADDR_W-1:0] r_cnt;
  port_id_t          r_rr;
  logic [1:0]        w_win;
  logic              w_valid;
  logic              w_grant;

  rr_pick2 u_pick (
    .req   ({req1, req0}),
    .rr    (r_rr),
    .win   (w_win),
    .valid (w_valid)
  );

  assign w_grant = (r_state == RUN) && w_valid;
  assign busy    = (r_state == INIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_rr    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (mem_read_enable) begin
        rdata <= mem_read_data;
      end
      // the loser of this cycle gets priority on the next tie
      if (w_grant) begin
        r_rr <= port_id_t'(w_win[0]);
      end
      if (r_state == INIT) begin
        if (r_cnt == c_last) begin
          r_state <= RUN;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (clear) begin
        r_state <= INIT;
        r_cnt   <= '0;
      end
    end
  end

  always_comb begin
    gnt0             = 1'b0;
    gnt1             = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    if (r_state == INIT) begin
      mem_address      = r_cnt;
      mem_write_enable = 1'b1;
    end else if (w_valid) begin
      gnt0 = w_win[0];
      gnt1 = w_win[1];
      if (w_win[1]) begin
        mem_address      = addr1;
        mem_write_data   = wdata1;
        mem_write_enable = we1;
        mem_read_enable  = ~we1;
      end else begin
        mem_address      = addr0;
        mem_write_data   = wdata0;
        mem_write_enable = we0;
        mem_read_enable  = ~we0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// +-----------------------------------------------------------------------+
// | tb_dmem_arbiter : directed bench with a cycle-level reference model   |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       reset, clear;
  logic       req0, req1, we0, we1;
  logic [3:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [3:0] rdata, mem_address, mem_write_data, mem_read_data;
  logic       mem_write_enable, mem_read_enable;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_read_data(mem_read_data)
  );

  // attached 16x4 memory with combinational read
  logic [3:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 4'h7;
  always @(posedge clk) if (mem_write_enable === 1'b1) mem[mem_address] <= mem_write_data;
  assign mem_read_data = mem[mem_address];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fill phase flag/progress, tie-break preference,
  // expected memory image and pending read results.
  bit         m_init  = 1'b1;
  int         m_cnt   = 0;
  int         m_pref  = 0;
  bit         m_rv0   = 1'b0;
  bit         m_rv1   = 1'b0;
  logic [3:0] m_rdata = 4'h0;
  logic [3:0] ref_mem [16];
  initial for (int i = 0; i < 16; i++) ref_mem[i] = 4'h7;

  always @(negedge clk) begin
    if (check_en) begin
      int         win;
      logic       e_g0, e_g1, e_we, e_re;
      logic [3:0] e_addr, e_wd;
      win = -1;
      e_g0 = 0; e_g1 = 0; e_we = 0; e_re = 0; e_addr = 0; e_wd = 0;
      if (m_init) begin
        e_addr = 4'(m_cnt);
        e_we   = 1;
      end else begin
        if (req0 && req1) win = m_pref;
        else if (req0)    win = 0;
        else if (req1)    win = 1;
        if (win == 0) begin
          e_g0 = 1; e_addr = addr0; e_we = we0; e_wd = wdata0; e_re = !we0;
        end else if (win == 1) begin
          e_g1 = 1; e_addr = addr1; e_we = we1; e_wd = wdata1; e_re = !we1;
        end
      end
      chk1("m_gnt0", gnt0, e_g0);
      chk1("m_gnt1", gnt1, e_g1);
      chk1("m_busy", busy, m_init);
      chk4("m_addr", mem_address, e_addr);
      chk4("m_wdata", mem_write_data, e_wd);
      chk1("m_we", mem_write_enable, e_we);
      chk1("m_re", mem_read_enable, e_re);
      chk1("m_rvalid0", rvalid0, m_rv0);
      chk1("m_rvalid1", rvalid1, m_rv1);
      chk4("m_rdata", rdata, m_rdata);

      // advance to the state expected after the next rising edge
      m_rv0 = (win == 0) && e_re;
      m_rv1 = (win == 1) && e_re;
      if (e_re) m_rdata = ref_mem[e_addr];
      if (e_we) ref_mem[e_addr] = e_wd;
      if (win >= 0) m_pref = 1 - win;
      if (m_init) begin
        if (m_cnt == 15) m_init = 0;
        else m_cnt++;
      end else if (clear) begin
        m_init = 1;
        m_cnt  = 0;
      end
      if (reset) begin
        m_init = 1; m_cnt = 0; m_pref = 0;
        m_rv0 = 0; m_rv1 = 0; m_rdata = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles starting at the next falling edge; returns at the
  // first non-busy falling edge.
  task automatic count_busy(input bit chk_addr, output int n);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 40) begin
      if (chk_addr) chk4("fill_addr", mem_address, n[3:0]);
      chk1("fill_we", mem_write_enable, 1'b1);
      chk1("fill_gnt0", gnt0, 1'b0);
      chk1("fill_gnt1", gnt1, 1'b0);
      chk1("fill_rv0", rvalid0, 1'b0);
      chk1("fill_rv1", rvalid1, 1'b0);
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    reset = 1; clear = 0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    check_en = 1;

    // power-up fill, then read back every address
    count_busy(1'b1, n);
    chki("fill_len_reset", n, 16);
    chk4("reset_rdata", rdata, 4'h0);
    chk1("reset_rvalid0", rvalid0, 1'b0);
    step();
    req0 = 1; we0 = 0;
    for (int a = 0; a < 16; a++) begin
      addr0 = 4'(a);
      step();
      @(negedge clk);
      chk1("scan_rvalid0", rvalid0, 1'b1);
      chk4("scan_rdata", rdata, 4'h0);
    end
    step();
    req0 = 0;

    // write then read-back on port 0
    req0 = 1; we0 = 1; addr0 = 4'd5; wdata0 = 4'hA;
    @(negedge clk); chk1("wr5_gnt0", gnt0, 1'b1);
    step(); we0 = 0;
    @(negedge clk); chk1("rd5_gnt0", gnt0, 1'b1);
    step(); req0 = 0;
    @(negedge clk);
    chk1("rd5_rvalid0", rvalid0, 1'b1);
    chk4("rd5_rdata", rdata, 4'hA);

    // lone port-1 access leaves the tie preference on port 0
    step();
    req1 = 1; we1 = 0; addr1 = 4'd0;
    step(); req1 = 0;

    // continuous contention alternates grants
    req0 = 1; we0 = 1; addr0 = 4'd3; wdata0 = 4'h1;
    req1 = 1; we1 = 0; addr1 = 4'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("alt_gnt0", gnt0, (i % 2) == 0);
      chk1("alt_gnt1", gnt1, (i % 2) == 1);
      if (i == 2) begin
        chk1("alt_rvalid1", rvalid1, 1'b1);
        chk4("alt_rdata", rdata, 4'h1);
      end
      step();
    end
    req0 = 0; req1 = 0;

    // clear in RUN wipes a freshly written word
    req1 = 1; we1 = 1; addr1 = 4'd15; wdata1 = 4'hF;
    step(); req1 = 0;
    clear = 1;
    step(); clear = 0;
    req0 = 1; we0 = 0; addr0 = 4'd15;
    count_busy(1'b1, n);
    chki("fill_len_clear", n, 16);
    chk1("clr_gnt0_after", gnt0, 1'b1);
    step(); req0 = 0;
    @(negedge clk);
    chk1("clr_rvalid0", rvalid0, 1'b1);
    chk4("clr_rdata", rdata, 4'h0);

    // reset in the middle of a fill with port 1 pending
    step();
    clear = 1;
    step(); clear = 0;
    req1 = 1; we1 = 0; addr1 = 4'd2;
    repeat (7) step();
    @(negedge clk); chk4("mid_fill_cnt", mem_address, 4'd7);
    step(); reset = 1;
    step(); reset = 0;
    count_busy(1'b1, n);
    chki("fill_len_rst_mid", n, 16);
    chk1("rst_gnt1_first", gnt1, 1'b1);
    step(); req1 = 0;
    @(negedge clk);
    chk1("rst_rvalid1", rvalid1, 1'b1);
    chk4("rst_rdata", rdata, 4'h0);

    // read granted in the same cycle as clear still completes
    step();
    req0 = 1; we0 = 1; addr0 = 4'd4; wdata0 = 4'h6;
    step(); we0 = 0; clear = 1;
    @(negedge clk); chk1("clrrd_gnt0", gnt0, 1'b1);
    step(); req0 = 0; clear = 0;
    @(negedge clk);
    chk1("clrrd_rvalid0", rvalid0, 1'b1);
    chk4("clrrd_rdata", rdata, 4'h6);
    chk1("clrrd_busy", busy, 1'b1);
    count_busy(1'b0, n);
    chki("clrrd_fill_rest", n, 15);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, tests %0d failed %0d", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sits between the CPU datapath and the 16x4 data memory and shares the single memory port between two requesters: port 0 (CPU load/store unit) and port 1 (debug/loader).
- Owns memory initialisation: after reset, or on a `clear` pulse, it walks every address and writes zero before granting any access.
- Arbitration is round-robin with at most one memory access per cycle.

Parameters:
- ADDR_W, 4, address width.
- DATA_W, 4, data width.
- DEPTH, 16, number of memory words (equals 2**ADDR_W).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- clear  in  1  one-cycle pulse; re-runs the zero-fill sequence
- req0, req1  in  1 each  access request; held until the matching gnt
- we0, we1  in  1 each  1 = write, 0 = read; held with req
- addr0, addr1  in  ADDR_W each  address; held with req
- wdata0, wdata1  in  DATA_W each  write data; held with req
- gnt0, gnt1  out  1 each  combinational grant; the access executes this cycle
- rvalid0, rvalid1  out  1 each  registered; read data valid one cycle after the read grant
- rdata  out  DATA_W  registered read data, shared by both ports
- busy  out  1  high while zero-fill is in progress
- mem_address  out  ADDR_W  to the memory
- mem_write_data  out  DATA_W  to the memory
- mem_write_enable  out  1  to the memory
- mem_read_enable  out  1  to the memory
- mem_read_data  in  DATA_W  from the memory; combinational read

Behaviour:
- FSM states:
  - INIT: fill counter cnt runs 0..DEPTH-1.
  - RUN: normal arbitration.
- Reset, synchronous and applied on any cycle, including mid-INIT or mid-transaction:
  - state goes to INIT and cnt to 0.
  - Round-robin pointer rr goes to 0.
  - rvalid0 and rvalid1 go to 0; rdata goes to 0.
- INIT, each cycle:
  - Drive mem_address=cnt, mem_write_data=0, mem_write_enable=1, mem_read_enable=0.
  - busy=1; gnt0 and gnt1 are held at 0.
  - When cnt==DEPTH-1, go to RUN; cnt does not wrap.
  - Total fill time is exactly DEPTH cycles, so busy falls on cycle DEPTH after reset deasserts.
  - clear during INIT is ignored; the fill is not restarted.
- RUN, winner selection:
  - Only req0 high: winner is port 0.
  - Only req1 high: winner is port 1.
  - Both high: winner is port rr.
  - Neither high: no winner.
- RUN, when there is a winner:
  - gnt of the winning port is 1; the other gnt is 0.
  - mem_address = winner's addr.
  - mem_write_enable = winner's we; mem_write_data = winner's wdata.
  - mem_read_enable = ~winner's we.
  - On the clock edge, rr <= the port that did not win. rr is unchanged when there is no winner.
- RUN with no winner: all mem_* outputs and both gnts are 0.
- Write timing: a write commits at the clock edge ending its grant cycle.
- Read timing:
  - On the grant edge, rdata <= mem_read_data and rvalid of the granted port <= 1. Both rvalids are 1-cycle pulses.
  - A read issued in the cycle after a write to the same address returns the new data.
- Between reads, rdata holds its last value.
- clear in RUN:
  - Takes effect at the next edge: state <= INIT and cnt <= 0.
  - An access granted in the same cycle as clear still completes, including its rvalid.
- Requesters keep req, we, addr and wdata stable until gnt. A request that is denied stays pending with no side effect.
- Back-to-back: the same port may be granted in consecutive cycles when the other port is idle.
- Fairness: under continuous contention, the ports alternate every cycle.

Decomposition:
- Shared package `dmem_pkg` holds:
  - ADDR_W, DATA_W, DEPTH constants.
  - `arb_state_t` enum {INIT, RUN}.
  - `port_id_t` as a 1-bit typedef.
- One sub-module, `rr_pick2`: a combinational 2-way round-robin picker. Inputs are req[1:0] and rr; outputs are a one-hot winner and a valid flag.
- Write the top as two processes: sequential (state, cnt, rr, rvalid, rdata) and combinational (gnt, mem_* mux).

Test Plan:
- Reset release, then a port-0 read of every address.
  - Required: busy=1 for exactly 16 cycles with mem_write_enable=1 and addresses 0..15.
  - Required: gnt stays 0 throughout the fill.
  - Required: every read returns rdata=0.
- Port 0 writes addr=5, data=0xA; next cycle port 0 reads addr=5.
  - Required: gnt0 in both cycles.
  - Required: rvalid0=1 one cycle after the read grant, with rdata=0xA.
- req0 and req1 held continuously with rr=0: port 0 writes addr 3 with 0x1; port 1 reads addr 3.
  - Required: gnt0, gnt1, gnt0, gnt1 on successive cycles.
  - Required: port 1's first read returns 0x1.
- Port 1 writes 0xF to addr=15, then `clear` is pulsed in RUN while port 0 holds a read of addr=15.
  - Required: busy rises for 16 cycles and gnt0 is withheld during the fill.
  - Required: the read is granted afterwards and returns rdata=0.
- Reset asserted at fill cycle 7, with req1 pending.
  - Required: the fill restarts at cnt=0 and completes in 16 cycles.
  - Required: rvalid stays 0 until then; req1 is granted first after the fill.
- Port 0 read granted in the same cycle as a `clear` pulse.
  - Required: rvalid0=1 on the next cycle with the old data, while busy=1.
